// File: rtl/cod5_fifo_stream_reader_pkg.sv
// Constants and helpers shared by the cod5 FIFO read-side stream reader.
package cod5_fifo_stream_reader_pkg;

    localparam int unsigned COD5_RDBUF_DEPTH = 2;

    // The sum is carried at 3 bits; pop implies occ >= 1, so it never underflows.
    function automatic logic [2:0] rdCredit(input logic [1:0] occ,
                                            input logic       inflight,
                                            input logic       pop);
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/cod5_fifo_stream_reader_skid.sv
// Two-entry register FIFO holding words captured from the cod5 FIFO read port.
module cod5_skid_buffer2
    import cod5_fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [1:0]            occ_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] mem_q [COD5_RDBUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [COD5_RDBUF_DEPTH];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;

    // Push and pop act on independent pointers; occupancy only moves when exactly one fires.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push_i) begin
            mem_d[tail_q] = data_i;
            tail_d        = ~tail_q;
        end
        if (pop_i) begin
            head_d = ~head_q;
        end
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q  <= '{default: '0};
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[head_q];

endmodule

// File: rtl/cod5_fifo_stream_reader.sv
// Read-side consumer for the cod5 async FIFO: turns its read port into a valid/ready stream.
module cod5_fifo_stream_reader
    import cod5_fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   fifo_inc_o,
    input  logic [DATA_WIDTH-1:0]  fifo_data_i,
    input  logic                   fifo_empty_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [DATA_WIDTH-1:0]  m_data_o,
    output logic [1:0]             level_o,
    output logic [COUNT_WIDTH-1:0] words_o
);

    logic                   inflight_q, inflight_d;
    logic [COUNT_WIDTH-1:0] words_q, words_d;
    logic [1:0]             occ;
    logic                   pop;

    assign m_valid_o = (occ != 2'd0);
    assign pop       = m_valid_o & m_ready_i;

    // A pop this cycle frees a slot, so a full buffer can reissue a read as soon as ready rises.
    // Never read while empty: the FIFO updates its data register on every increment.
    assign fifo_inc_o = !rst_i && !fifo_empty_i &&
                        (rdCredit(occ, inflight_q, pop) < 3'(COD5_RDBUF_DEPTH));

    always_comb begin
        inflight_d = fifo_inc_o;
        words_d    = words_q;
        if (pop) begin
            words_d = words_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= 1'b0;
            words_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            words_q    <= words_d;
        end
    end

    cod5_skid_buffer2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push_i(inflight_q),
        .data_i(fifo_data_i),
        .pop_i (pop),
        .occ_o (occ),
        .head_o(m_data_o)
    );

    assign level_o = occ;
    assign words_o = words_q;

endmodule
